// File: rtl/clk_en_gen_pkg.sv
// Shared types, reset constants and the channel-index width helper for clk_en_gen.
// Channel state is held at ACC_MAX_W bits; ACC_W must not exceed ACC_MAX_W.
package clk_en_gen_pkg;

  localparam int unsigned ACC_MAX_W = 32;

  typedef logic [ACC_MAX_W-1:0] acc_t;

  typedef struct packed {
    acc_t num;
    acc_t den;
    acc_t acc;
  } ch_state_t;

  localparam acc_t RST_NUM = acc_t'(1);
  localparam acc_t RST_DEN = acc_t'(1);

  typedef enum logic [0:0] {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } cfg_state_e;

  // max(1, clog2(n)) so a single-channel build still has a one-bit select
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_en_gen_frac_acc_ch.sv
// One fractional enable channel: phase accumulator, carry compare, clamp/disable.
// Optional toggle output is built only when CLK_EN_GEN_TOGGLE_EN is defined.
module frac_acc_ch
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             apply,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
`ifdef CLK_EN_GEN_TOGGLE_EN
  output logic             outclk,
`endif
  output logic             cen
);

  ch_state_t          st;
  ch_state_t          st_next;
  logic               cen_next;
  logic               enabled;
  logic [ACC_MAX_W:0] sum;
  acc_t               num_ld;

  assign enabled = (st.den != '0) && (st.num != '0);
  assign sum     = {1'b0, st.acc} + {1'b0, st.num};

  // num above den would need two carries per cycle; clamp to one carry every cycle
  assign num_ld  = ((cfg_den != '0) && (cfg_num > cfg_den)) ? acc_t'(cfg_den)
                                                            : acc_t'(cfg_num);

  always_comb begin
    st_next  = st;
    cen_next = 1'b0;
    if (apply) begin
      st_next.num = num_ld;
      st_next.den = acc_t'(cfg_den);
      st_next.acc = '0;
    end else if (!enabled) begin
      st_next.acc = '0;
    end else if (sum >= {1'b0, st.den}) begin
      st_next.acc = acc_t'(sum - {1'b0, st.den});
      cen_next    = 1'b1;
    end else begin
      st_next.acc = acc_t'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= '{num: RST_NUM, den: RST_DEN, acc: '0};
      cen <= 1'b0;
    end else begin
      st  <= st_next;
      cen <= cen_next;
    end
  end

`ifdef CLK_EN_GEN_TOGGLE_EN
  logic outclk_next;

  // flips on the same edge that registers cen high
  always_comb begin
    outclk_next = outclk;
    if (apply) begin
      outclk_next = 1'b0;
    end else if (cen_next) begin
      outclk_next = ~outclk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outclk <= 1'b0;
    end else begin
      outclk <= outclk_next;
    end
  end
`endif

endmodule

// File: rtl/clk_en_gen.sv
// Fractional clock-enable generator top: config handshake, apply decode, lock counter.
// Define CLK_EN_GEN_TOGGLE_EN to add the per-channel outclk square-wave port.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 3,
  parameter  int unsigned ACC_W    = 16,
  parameter  int unsigned LOCK_DLY = 16,
  localparam int unsigned CH_W     = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  output logic [NUM_CH-1:0] cen,
`ifdef CLK_EN_GEN_TOGGLE_EN
  output logic [NUM_CH-1:0] outclk,
`endif
  output logic              locked
);

  localparam int unsigned       LOCK_W   = $clog2(LOCK_DLY + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_DLY);

  cfg_state_e        state;
  cfg_state_e        state_next;
  logic              accept;
  logic              apply;
  logic [CH_W-1:0]   ch_q;
  logic [ACC_W-1:0]  num_q;
  logic [ACC_W-1:0]  den_q;
  logic [NUM_CH-1:0] apply_ch;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_cnt_next;
  logic              locked_next;

  assign cfg_ready = (state == CFG_IDLE) && !rst;
  assign accept    = cfg_valid && cfg_ready;
  assign apply     = (state == CFG_APPLY);

  always_comb begin
    state_next = state;
    case (state)
      CFG_IDLE:  if (accept) state_next = CFG_APPLY;
      CFG_APPLY: state_next = CFG_IDLE;
      default:   state_next = CFG_IDLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= CFG_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge refclk) begin
    if (accept) begin
      ch_q  <= cfg_ch;
      num_q <= cfg_num;
      den_q <= cfg_den;
    end
  end

  // out-of-range channel selects match no decode line but still restart the lock
  always_comb begin
    lock_cnt_next = lock_cnt;
    if (apply) begin
      lock_cnt_next = '0;
    end else if (lock_cnt != LOCK_MAX) begin
      lock_cnt_next = lock_cnt + 1'b1;
    end
    locked_next = (lock_cnt_next == LOCK_MAX);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_next;
      locked   <= locked_next;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    assign apply_ch[i] = apply && (ch_q == CH_W'(i));

    frac_acc_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk     (refclk),
      .rst     (rst),
      .apply   (apply_ch[i]),
      .cfg_num (num_q),
      .cfg_den (den_q),
`ifdef CLK_EN_GEN_TOGGLE_EN
      .outclk  (outclk[i]),
`endif
      .cen     (cen[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: vector table, hand sequences and a
// carry-count reference model (carries after k steps = floor(k*num/den)).
module tb_clk_en_gen;

  localparam int NUM_CH   = 3;
  localparam int ACC_W    = 16;
  localparam int LOCK_DLY = 16;
  localparam int CH_W     = 2;

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_num;
  logic [ACC_W-1:0]  cfg_den;
  logic [NUM_CH-1:0] cen;
  logic              locked;
`ifdef CLK_EN_GEN_TOGGLE_EN
  logic [NUM_CH-1:0] outclk;
`endif

  clk_en_gen #(
    .NUM_CH   (NUM_CH),
    .ACC_W    (ACC_W),
    .LOCK_DLY (LOCK_DLY)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cen       (cen),
`ifdef CLK_EN_GEN_TOGGLE_EN
    .outclk    (outclk),
`endif
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: per-channel ratio and steps since last (re)start
  longint m_num [NUM_CH];
  longint m_den [NUM_CH];
  longint m_k   [NUM_CH];
  bit     m_known [NUM_CH];
  bit     m_pend;
  int     p_ch;
  longint p_num, p_den;
  int     since;

  typedef struct {
    int          ch;
    int          num;
    int          den;
    int          len;
    logic [15:0] pat;
  } vec_t;

  vec_t tab [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint carries(input longint n, input longint d, input longint k);
    if (n == 0 || d == 0) return 0;
    return (k * n) / d;
  endfunction

  function automatic bit exp_cen(input int i);
    if (m_k[i] < 1) return 1'b0;
    return carries(m_num[i], m_den[i], m_k[i]) != carries(m_num[i], m_den[i], m_k[i] - 1);
  endfunction

  function automatic bit exp_out(input int i);
    return carries(m_num[i], m_den[i], m_k[i]) % 2 == 1;
  endfunction

  task automatic model_edge(input bit r, input bit v, input int c, input longint n, input longint d);
    bit app;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_num[i] = 1; m_den[i] = 1; m_k[i] = 0; m_known[i] = 1'b1;
      end
      m_pend = 1'b0;
      since  = 0;
    end else begin
      app = m_pend;
      for (int i = 0; i < NUM_CH; i++) begin
        if (app && p_ch == i) begin
          m_den[i]   = p_den;
          m_num[i]   = (p_den != 0 && p_num > p_den) ? p_den : p_num;
          m_k[i]     = 0;
          m_known[i] = 1'b0;
        end else begin
          m_k[i]++;
          m_known[i] = 1'b1;
        end
      end
      since  = app ? 0 : since + 1;
      m_pend = v && !app;
      if (m_pend) begin
        p_ch = c; p_num = n; p_den = d;
      end
    end
  endtask

  task automatic step();
    bit r, v;
    int c;
    longint n, d;
    r = rst; v = cfg_valid; c = int'(cfg_ch);
    n = longint'(cfg_num); d = longint'(cfg_den);
    @(posedge refclk);
    #1;
    model_edge(r, v, c, n, d);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_known[i]) check($sformatf("cen[%0d]", i), 32'(cen[i]), 32'(exp_cen(i)));
`ifdef CLK_EN_GEN_TOGGLE_EN
      check($sformatf("outclk[%0d]", i), 32'(outclk[i]), 32'(exp_out(i)));
`endif
    end
    check("locked", 32'(locked), 32'(since >= LOCK_DLY));
    check("cfg_ready", 32'(cfg_ready), 32'(!rst && !m_pend));
  endtask

  task automatic do_cfg(input int c, input int n, input int d);
    int guard;
    guard = 0;
    while (m_pend && guard < 10) begin
      step();
      guard++;
    end
    check("cfg_wait_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(c);
    cfg_num   = ACC_W'(n);
    cfg_den   = ACC_W'(d);
    step();
    cfg_valid = 1'b0;
    step();
    check("locked_after_apply", 32'(locked), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lock_edge;
    logic [3:0]  pat4;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0;
    pat4 = 4'b0110;

    // pattern bit j is cen[ch] j+2 edges after the accepting edge
    tab[0] = '{ch: 1, num: 4, den: 5, len: 5, pat: 16'b11110};
    tab[1] = '{ch: 2, num: 1, den: 2, len: 2, pat: 16'b10};
    tab[2] = '{ch: 0, num: 5, den: 0, len: 1, pat: 16'b0};
    tab[3] = '{ch: 0, num: 7, den: 3, len: 1, pat: 16'b1};
    tab[4] = '{ch: 0, num: 2, den: 3, len: 3, pat: 16'b110};
    tab[5] = '{ch: 1, num: 3, den: 8, len: 8, pat: 16'b10100100};
    tab[6] = '{ch: 3, num: 9, den: 9, len: 0, pat: 16'b0};

    repeat (2) step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_num = 16'd4; cfg_den = 16'd5;
    step();
    cfg_valid = 1'b0; rst = 1'b0;

    lock_edge = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (locked === 1'b1 && lock_edge == 0) lock_edge = j;
    end
    check("lock_rise_edge", 32'(lock_edge), 32'(LOCK_DLY));
    check("cen_free_run", 32'(cen), 32'd7);

    for (int r = 0; r < 7; r++) begin
      do_cfg(tab[r].ch, tab[r].num, tab[r].den);
      for (int j = 0; j < 2 * tab[r].len; j++) begin
        step();
        check($sformatf("vec%0d_cen", r), 32'(cen[tab[r].ch]), 32'(tab[r].pat[j % tab[r].len]));
`ifdef CLK_EN_GEN_TOGGLE_EN
        if (tab[r].ch == 2 && tab[r].den == 2)
          check("outclk2_seq", 32'(outclk[2]), 32'(pat4[j % 4]));
`endif
      end
      repeat (LOCK_DLY + 2) step();
    end

    // back-to-back requests with cfg_valid held high
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_num = 16'd1; cfg_den = 16'd2;
    step();
    check("b2b_ready_low", 32'(cfg_ready), 32'd0);
    cfg_ch = 2'd2; cfg_num = 16'd1; cfg_den = 16'd1;
    step();
    check("b2b_ready_high", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    check("b2b_ready_low2", 32'(cfg_ready), 32'd0);
    step();
    check("b2b_locked", 32'(locked), 32'd0);
    repeat (LOCK_DLY + 4) step();

    // reset with a pending apply and the lock counter mid-way
    do_cfg(1, 4, 5);
    repeat (6) step();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_num = 16'd0; cfg_den = 16'd0;
    step();
    cfg_valid = 1'b0; rst = 1'b1;
    step();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_cen", 32'(cen), 32'd0);
    rst = 1'b0;
    repeat (4) step();
    check("rst_defaults", 32'(cen), 32'd7);

    for (int t = 0; t < 500; t++) begin
      rst       = ($urandom_range(0, 59) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        cfg_num = ACC_W'($urandom);
        cfg_den = ACC_W'($urandom);
      end else begin
        cfg_num = ACC_W'($urandom_range(0, 9));
        cfg_den = ACC_W'($urandom_range(0, 9));
      end
      step();
    end
    rst = 1'b0; cfg_valid = 1'b0;
    repeat (LOCK_DLY + 2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
